// File: rtl/sparse_mac_block_p.sv
// Sparse dot-product engine. It latches one vector of activations, weights
// and a nonzero mask, then walks the mask MACS set bits per pass, starting
// from the lowest index. The result is held on a valid/ready output until it
// is consumed.
module sparse_mac_block_p #(
  parameter int N_ELEM   = 8,
  parameter int DATA_W   = 8,
  parameter int MACS     = 4,
  parameter int ACC_W    = 18,
  parameter int SATURATE = 1
) (
  input  logic                       clk,
  input  logic                       reset_async,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_ELEM-1:0]          in_mask,
  input  logic [N_ELEM*DATA_W-1:0]   in_act,
  input  logic [N_ELEM*DATA_W-1:0]   in_wgt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_result,
  output logic                       out_sat,
  output logic [$clog2(N_ELEM+1)-1:0] out_nnz,
  output logic [$clog2(N_ELEM+1)-1:0] out_passes,
  output logic                       busy
);

  localparam int CW       = $clog2(N_ELEM+1);
  localparam int PW       = 2*DATA_W;
  localparam int ACC_FULL = 2*DATA_W + $clog2(N_ELEM) + 1;
  // One guard bit above the wider of the accumulator and the output keeps
  // the range test correct for any ACC_W.
  localparam int EXT      = ((ACC_W > ACC_FULL) ? ACC_W : ACC_FULL) + 1;

  localparam logic [CW-1:0]         MACS_C  = CW'(MACS);
  localparam logic signed [EXT-1:0] SAT_MAX = {{(EXT-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [N_ELEM-1:0]              rem_mask, rem_nxt, sel;
  logic [N_ELEM-1:0][CW-1:0]      rank;
  logic [N_ELEM-1:0][DATA_W-1:0]  act_r, wgt_r;
  logic [MACS-1:0][DATA_W-1:0]    slot_a, slot_b;
  logic [MACS-1:0]                slot_en;
  logic [MACS-1:0][PW-1:0]        prod;
  logic signed [ACC_FULL-1:0]     acc, acc_nxt;
  logic signed [EXT-1:0]          acc_ext;
  logic [CW-1:0]                  pass_cnt, nnz_r, in_nnz;
  logic [ACC_W-1:0]               res_nxt;
  logic                           sat_nxt;

  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // State register.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) state <= IDLE;
    else             state <= state_nxt;
  end

  // Handshake and next state; a consumed result can be replaced on the same edge.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    accept    = in_valid && in_ready;
    case (state)
      IDLE: if (accept) state_nxt = (in_mask == '0) ? DONE : RUN;
      RUN:  if (rem_nxt == '0) state_nxt = DONE;
      DONE: if (out_ready) begin
              if (in_valid) state_nxt = (in_mask == '0) ? DONE : RUN;
              else          state_nxt = IDLE;
            end
      default: state_nxt = IDLE;
    endcase
  end

  // Popcount of the incoming mask.
  always_comb begin
    in_nnz = '0;
    for (int i = 0; i < N_ELEM; i++) in_nnz = in_nnz + CW'(in_mask[i]);
  end

  // Rank each remaining set bit; the lowest MACS ranks are served this pass.
  always_comb begin
    logic [CW-1:0] cnt;
    cnt  = '0;
    sel  = '0;
    rank = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      rank[i] = cnt;
      if (rem_mask[i]) begin
        if (cnt < MACS_C) sel[i] = 1'b1;
        cnt = cnt + 1'b1;
      end
    end
    rem_nxt = rem_mask & ~sel;
  end

  // Route the selected element of rank k onto multiplier slot k.
  always_comb begin
    slot_en = '0;
    slot_a  = '0;
    slot_b  = '0;
    for (int k = 0; k < MACS; k++) begin
      for (int i = 0; i < N_ELEM; i++) begin
        if (sel[i] && (rank[i] == CW'(k))) begin
          slot_en[k] = 1'b1;
          slot_a[k]  = act_r[i];
          slot_b[k]  = wgt_r[i];
        end
      end
    end
  end

  // One signed multiplier per slot; idle slots contribute zero.
  for (genvar g = 0; g < MACS; g++) begin : g_lane
    logic signed [PW-1:0] p;
    assign p       = $signed(slot_a[g]) * $signed(slot_b[g]);
    assign prod[g] = slot_en[g] ? p : '0;
  end

  // Sign-extend and add this pass's products to the running sum.
  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < MACS; k++)
      acc_nxt = acc_nxt + {{(ACC_FULL-PW){prod[k][PW-1]}}, prod[k]};
  end

  // Convert the final full-precision sum to the output width.
  always_comb begin
    acc_ext = {{(EXT-ACC_FULL){acc_nxt[ACC_FULL-1]}}, acc_nxt};
    sat_nxt = (acc_ext > SAT_MAX) || (acc_ext < SAT_MIN);
    res_nxt = acc_ext[ACC_W-1:0];
    if (SATURATE != 0) begin
      if (acc_ext > SAT_MAX)      res_nxt = SAT_MAX[ACC_W-1:0];
      else if (acc_ext < SAT_MIN) res_nxt = SAT_MIN[ACC_W-1:0];
    end
  end

  // Operand capture, pass iteration and output load.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      act_r      <= '0;
      wgt_r      <= '0;
      rem_mask   <= '0;
      acc        <= '0;
      pass_cnt   <= '0;
      nnz_r      <= '0;
      out_result <= '0;
      out_sat    <= 1'b0;
      out_nnz    <= '0;
      out_passes <= '0;
    end else if (accept) begin
      act_r    <= in_act;
      wgt_r    <= in_wgt;
      rem_mask <= in_mask;
      acc      <= '0;
      pass_cnt <= '0;
      nnz_r    <= in_nnz;
      if (in_mask == '0) begin
        out_result <= '0;
        out_sat    <= 1'b0;
        out_nnz    <= '0;
        out_passes <= '0;
      end
    end else if (state == RUN) begin
      acc      <= acc_nxt;
      rem_mask <= rem_nxt;
      pass_cnt <= pass_cnt + 1'b1;
      if (rem_nxt == '0) begin
        out_result <= res_nxt;
        out_sat    <= sat_nxt;
        out_nnz    <= nnz_r;
        out_passes <= pass_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sparse_mac_block_p.sv
// Bench for sparse_mac_block_p: three instances (default, wrap mode, one
// multiplier) share the data bus; each has its own handshake signals.
module tb_sparse_mac_block_p;
  localparam int N = 8, DW = 8, AW = 18, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_async;
  logic [N-1:0]  in_mask;
  logic [N*DW-1:0] in_act, in_wgt;
  logic          in_valid_v[3], out_ready_v[3];
  logic          in_ready_v[3], out_valid_v[3], out_sat_v[3], busy_v[3];
  logic [AW-1:0] out_result_v[3];
  logic [CW-1:0] out_nnz_v[3], out_passes_v[3];

  int vectors = 0, miscompares = 0;

  sparse_mac_block_p #(.N_ELEM(N), .DATA_W(DW), .MACS(4), .ACC_W(AW), .SATURATE(1)) dut0 (
    .clk(clk), .reset_async(reset_async), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_mask(in_mask), .in_act(in_act), .in_wgt(in_wgt), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_result(out_result_v[0]), .out_sat(out_sat_v[0]),
    .out_nnz(out_nnz_v[0]), .out_passes(out_passes_v[0]), .busy(busy_v[0]));

  sparse_mac_block_p #(.N_ELEM(N), .DATA_W(DW), .MACS(4), .ACC_W(AW), .SATURATE(0)) dut1 (
    .clk(clk), .reset_async(reset_async), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_mask(in_mask), .in_act(in_act), .in_wgt(in_wgt), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_result(out_result_v[1]), .out_sat(out_sat_v[1]),
    .out_nnz(out_nnz_v[1]), .out_passes(out_passes_v[1]), .busy(busy_v[1]));

  sparse_mac_block_p #(.N_ELEM(N), .DATA_W(DW), .MACS(1), .ACC_W(AW), .SATURATE(1)) dut2 (
    .clk(clk), .reset_async(reset_async), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_mask(in_mask), .in_act(in_act), .in_wgt(in_wgt), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out_result(out_result_v[2]), .out_sat(out_sat_v[2]),
    .out_nnz(out_nnz_v[2]), .out_passes(out_passes_v[2]), .busy(busy_v[2]));

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer dot product, then the output rules.
  task automatic model(input logic [N-1:0] m, input logic [N*DW-1:0] a, input logic [N*DW-1:0] w,
                       input int macs, input bit satur,
                       output longint res, output longint sat, output longint nnz, output longint passes);
    longint sum, lim, av, wv;
    sum = 0; nnz = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        av = longint'($signed(a[i*DW +: DW]));
        wv = longint'($signed(w[i*DW +: DW]));
        sum += av * wv;
        nnz++;
      end
    end
    passes = (nnz + macs - 1) / macs;
    lim = longint'(1) << (AW-1);
    sat = (sum > lim - 1 || sum < -lim) ? 1 : 0;
    if (satur) res = (sum > lim - 1) ? lim - 1 : (sum < -lim) ? -lim : sum;
    else begin
      res = sum & ((longint'(1) << AW) - 1);
      if (res >= lim) res -= (longint'(1) << AW);
    end
  endtask

  // Full transaction on instance u, starting and ending at a falling edge.
  task automatic do_op(input int u, input logic [N-1:0] m, input logic [N*DW-1:0] a,
                       input logic [N*DW-1:0] w);
    longint er, es, en, ep;
    int t, lat, bsy;
    model(m, a, w, (u == 2) ? 1 : 4, (u != 1), er, es, en, ep);
    in_mask = m; in_act = a; in_wgt = w;
    in_valid_v[u] = 1'b1; out_ready_v[u] = 1'b0;
    t = 0;
    while (!in_ready_v[u] && t < 50) begin @(negedge clk); t++; end
    chk("in_ready", longint'(in_ready_v[u]), 1);
    @(posedge clk); #1 in_valid_v[u] = 1'b0;
    lat = 0; bsy = 0;
    @(negedge clk);
    while (!out_valid_v[u] && lat < 64) begin
      if (busy_v[u]) bsy++;
      @(negedge clk); lat++;
    end
    chk("latency", lat, ep);
    chk("busy_cycles", bsy, ep);
    chk("out_valid", longint'(out_valid_v[u]), 1);
    chk("result", longint'($signed(out_result_v[u])), er);
    chk("sat", longint'(out_sat_v[u]), es);
    chk("nnz", longint'(out_nnz_v[u]), en);
    chk("passes", longint'(out_passes_v[u]), ep);
    out_ready_v[u] = 1'b1;
    @(posedge clk); #1 out_ready_v[u] = 1'b0;
    @(negedge clk);
    chk("valid_cleared", longint'(out_valid_v[u]), 0);
    chk("result_kept", longint'($signed(out_result_v[u])), er);
  endtask

  initial begin
    logic [N*DW-1:0] a, w;
    logic [N-1:0] m;
    for (int u = 0; u < 3; u++) begin in_valid_v[u] = 1'b0; out_ready_v[u] = 1'b0; end
    in_mask = '0; in_act = '0; in_wgt = '0;
    reset_async = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_valid", longint'(out_valid_v[u]), 0);
      chk("rst_ready", longint'(in_ready_v[u]), 1);
      chk("rst_busy", longint'(busy_v[u]), 0);
      chk("rst_result", longint'(out_result_v[u]), 0);
    end
    reset_async = 1'b0;
    @(negedge clk);

    // act[i]=i+1, wgt=2, low four elements
    for (int i = 0; i < N; i++) begin a[i*DW +: DW] = DW'(i+1); w[i*DW +: DW] = 8'd2; end
    do_op(0, 8'h0F, a, w);
    chk("tp1_result", longint'($signed(out_result_v[0])), 20);
    chk("tp1_passes", longint'(out_passes_v[0]), 1);

    // all act=10, wgt=-3
    for (int i = 0; i < N; i++) begin a[i*DW +: DW] = 8'd10; w[i*DW +: DW] = 8'hFD; end
    do_op(0, 8'hFF, a, w);
    chk("tp2_result", longint'($signed(out_result_v[0])), -240);
    chk("tp2_passes", longint'(out_passes_v[0]), 2);

    do_op(0, 8'h00, a, w);
    chk("tp3_result", longint'($signed(out_result_v[0])), 0);

    // largest positive sum, clamp vs wrap
    for (int i = 0; i < N; i++) begin a[i*DW +: DW] = 8'h80; w[i*DW +: DW] = 8'h80; end
    do_op(0, 8'hFF, a, w);
    chk("sat_clamp", longint'($signed(out_result_v[0])), 131071);
    chk("sat_flag1", longint'(out_sat_v[0]), 1);
    do_op(1, 8'hFF, a, w);
    chk("sat_wrap", longint'($signed(out_result_v[1])), -131072);
    chk("sat_flag0", longint'(out_sat_v[1]), 1);

    // backpressure then same-edge handoff
    for (int i = 0; i < N; i++) begin a[i*DW +: DW] = 8'd3; w[i*DW +: DW] = 8'd4; end
    in_mask = 8'h3C; in_act = a; in_wgt = w; in_valid_v[0] = 1'b1;
    @(posedge clk); #1 in_valid_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", longint'(out_valid_v[0]), 1);
      chk("bp_result", longint'($signed(out_result_v[0])), 48);
      chk("bp_in_ready", longint'(in_ready_v[0]), 0);
      @(negedge clk);
    end
    a = '0; w = '0; a[7:0] = 8'd7; w[7:0] = 8'd5;
    in_mask = 8'h01; in_act = a; in_wgt = w; in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    #1 chk("handoff_ready", longint'(in_ready_v[0]), 1);
    @(posedge clk); #1 begin in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b0; end
    @(negedge clk);
    chk("handoff_run", longint'(busy_v[0]), 1);
    @(negedge clk);
    chk("handoff_valid", longint'(out_valid_v[0]), 1);
    chk("handoff_result", longint'($signed(out_result_v[0])), 35);
    out_ready_v[0] = 1'b1; @(posedge clk); #1 out_ready_v[0] = 1'b0; @(negedge clk);

    // random vectors on each instance
    for (int n = 0; n < 30; n++) begin
      a = {$urandom, $urandom}; w = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: m = 8'hFF;
        1: m = 8'h00;
        default: m = 8'($urandom);
      endcase
      do_op(n % 3, m, a, w);
    end

    // reset in the middle of the third pass with one multiplier
    a = {$urandom, $urandom}; w = {$urandom, $urandom};
    do_op(2, 8'h7E, a, w);
    in_mask = 8'hFF; in_act = a; in_wgt = w; in_valid_v[2] = 1'b1;
    @(posedge clk); #1 in_valid_v[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", longint'(busy_v[2]), 1);
    reset_async = 1'b1;
    #1;
    chk("mid_rst_busy", longint'(busy_v[2]), 0);
    chk("mid_rst_valid", longint'(out_valid_v[2]), 0);
    chk("mid_rst_result", longint'(out_result_v[2]), 0);
    chk("mid_rst_nnz", longint'(out_nnz_v[2]), 0);
    chk("mid_rst_passes", longint'(out_passes_v[2]), 0);
    @(negedge clk); reset_async = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", longint'(in_ready_v[2]), 1);
    do_op(2, 8'h03, a, w);
    chk("post_rst_passes", longint'(out_passes_v[2]), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
